// File: rtl/multicycle_datapath_if.sv
// Memory-side bus of the multicycle datapath: instruction fetch port and
// the request/ready data-memory port. The core drives it through the master
// modport and the memory system through the slave modport.
interface multicycle_datapath_if #(
   parameter int XLEN  = 64,
   parameter int IM_AW = 8,
   parameter int DM_AW = 5
);
   logic [IM_AW-1:0] im_addr;
   logic [31:0]      im_data;
   logic             dm_req;
   logic             dm_ready;
   logic             dm_we;
   logic [DM_AW-1:0] dm_addr;
   logic [XLEN-1:0]  dm_wdata;
   logic [XLEN-1:0]  dm_rdata;

   modport master (
      output im_addr,
      input  im_data,
      output dm_req,
      input  dm_ready,
      output dm_we,
      output dm_addr,
      output dm_wdata,
      input  dm_rdata
   );

   modport slave (
      input  im_addr,
      output im_data,
      input  dm_req,
      output dm_ready,
      input  dm_we,
      input  dm_addr,
      input  dm_wdata,
      output dm_rdata
   );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle RV-subset datapath: FETCH/DECODE/EXEC/MEM/WB/HALT state machine
// with a 32-entry register file, word loads/stores over a request/ready data
// port, and conditional branches. An unsupported opcode/funct3 parks the core
// in HALT until reset.
// Optional feature macro RETIRE_COUNT_EN: when defined, retire_cnt counts
// retired instructions (wrapping at 2^32); otherwise retire_cnt is tied to 0.
module multicycle_datapath #(
   parameter int XLEN  = 64,
   parameter int IM_AW = 8,
   parameter int DM_AW = 5
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   multicycle_datapath_if.master  bus,
   output logic                   halted,
   output logic [31:0]            retire_cnt
);

   // byte-offset bits dropped when forming a data-memory word address
   localparam int LG = $clog2(XLEN / 8);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // word-sized load/store: ld/sd on RV64, lw/sw on RV32
   localparam logic [2:0] F3_LDST = (XLEN == 64) ? 3'b011 : 3'b010;

   localparam logic [XLEN-1:0] PC_INC = {{(XLEN-3){1'b0}}, 3'd4};

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [XLEN-1:0]        r_pc;
   logic [31:0]            r_ir;
   logic signed [XLEN-1:0] r_a;
   logic signed [XLEN-1:0] r_b;
   logic signed [XLEN-1:0] r_imm;
   logic [XLEN-1:0]        r_aluout;
   logic [XLEN-1:0]        r_mdr;
   logic [XLEN-1:0]        r_x [0:31];

   logic [6:0]             w_opc;
   logic [4:0]             w_rd;
   logic [2:0]             w_f3;
   logic [4:0]             w_rs1;
   logic [4:0]             w_rs2;
   logic                   w_sub;
   logic                   w_legal;
   logic                   w_taken;
   logic signed [XLEN-1:0] w_rs1_val;
   logic signed [XLEN-1:0] w_rs2_val;
   logic signed [XLEN-1:0] w_imm;
   logic signed [XLEN-1:0] w_opb;
   logic signed [XLEN-1:0] w_alu;

   // ---------------------------------------------------------------------
   // Decode helpers
   // ---------------------------------------------------------------------
   function automatic logic f_legal(input logic [6:0] opc, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (opc)
         OPC_OP, OPC_OPIMM: ok = (f3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010, 3'b011});
         OPC_LOAD, OPC_STORE: ok = (f3 == F3_LDST);
         OPC_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic signed [XLEN-1:0] f_imm(input logic [31:0] ir);
      logic signed [XLEN-1:0] imm;
      case (ir[6:0])
         OPC_STORE:  imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
         OPC_BRANCH: imm = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
         default:    imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
      endcase
      return imm;
   endfunction

   function automatic logic signed [XLEN-1:0] f_alu(input logic signed [XLEN-1:0] a,
                                                    input logic signed [XLEN-1:0] b,
                                                    input logic [2:0]             f3,
                                                    input logic                   sub);
      logic signed [XLEN-1:0] y;
      case (f3)
         3'b000:  y = sub ? (a - b) : (a + b);
         3'b111:  y = a & b;
         3'b110:  y = a | b;
         3'b100:  y = a ^ b;
         3'b010:  y = {{(XLEN-1){1'b0}}, (a < b)};
         3'b011:  y = {{(XLEN-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
         default: y = '0;
      endcase
      return y;
   endfunction

   function automatic logic f_branch(input logic signed [XLEN-1:0] a,
                                     input logic signed [XLEN-1:0] b,
                                     input logic [2:0]             f3);
      logic t;
      case (f3)
         3'b000:  t = (a == b);
         3'b001:  t = (a != b);
         3'b100:  t = (a < b);
         3'b101:  t = (a >= b);
         3'b110:  t = ($unsigned(a) < $unsigned(b));
         3'b111:  t = ($unsigned(a) >= $unsigned(b));
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   assign w_opc   = r_ir[6:0];
   assign w_rd    = r_ir[11:7];
   assign w_f3    = r_ir[14:12];
   assign w_rs1   = r_ir[19:15];
   assign w_rs2   = r_ir[24:20];
   // funct7[5] selects sub only for register-register ops; OP-IMM reuses
   // that bit as part of the immediate
   assign w_sub   = (w_opc == OPC_OP) && r_ir[30];
   assign w_legal = f_legal(w_opc, w_f3);
   assign w_imm   = f_imm(r_ir);

   // x0 is hard-wired to zero regardless of what the array holds
   assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_x[w_rs1];
   assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_x[w_rs2];

   assign w_opb   = (w_opc == OPC_OP) ? r_b : r_imm;
   assign w_alu   = f_alu(r_a, w_opb, w_f3, w_sub);
   assign w_taken = f_branch(r_a, r_b, w_f3);

   // ---------------------------------------------------------------------
   // Outputs: the memory request is a pure decode of the MEM state, so an
   // asynchronous reset drops it in the same instant
   // ---------------------------------------------------------------------
   assign bus.im_addr  = r_pc[IM_AW+1:2];
   assign bus.dm_req   = (r_state == S_MEM);
   assign bus.dm_we    = (r_state == S_MEM) && (w_opc == OPC_STORE);
   assign bus.dm_addr  = r_aluout[DM_AW+LG-1:LG];
   assign bus.dm_wdata = r_b;
   assign halted       = (r_state == S_HALT);

   // state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // next-state selection
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
         S_EXEC: begin
            case (w_opc)
               OPC_OP, OPC_OPIMM:   w_next = S_WB;
               OPC_LOAD, OPC_STORE: w_next = S_MEM;
               OPC_BRANCH:          w_next = S_FETCH;
               default:             w_next = S_HALT;
            endcase
         end
         S_MEM: begin
            if (bus.dm_ready) w_next = (w_opc == OPC_STORE) ? S_FETCH : S_WB;
         end
         S_WB:     w_next = S_FETCH;
         S_HALT:   w_next = S_HALT;
         default:  w_next = S_HALT;
      endcase
   end

   // datapath registers and register file, updated per state
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_pc     <= '0;
         r_ir     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_imm    <= '0;
         r_aluout <= '0;
         r_mdr    <= '0;
         for (int i = 0; i < 32; i++) r_x[i] <= '0;
      end else begin
         case (r_state)
            S_FETCH: r_ir <= bus.im_data;
            S_DECODE: begin
               r_a   <= w_rs1_val;
               r_b   <= w_rs2_val;
               r_imm <= w_imm;
            end
            S_EXEC: begin
               if (w_opc == OPC_BRANCH)
                  r_pc <= w_taken ? (r_pc + r_imm) : (r_pc + PC_INC);
               else if ((w_opc == OPC_LOAD) || (w_opc == OPC_STORE))
                  r_aluout <= r_a + r_imm;
               else
                  r_aluout <= w_alu;
            end
            S_MEM: begin
               if (bus.dm_ready) begin
                  if (w_opc == OPC_STORE) r_pc  <= r_pc + PC_INC;
                  else                    r_mdr <= bus.dm_rdata;
               end
            end
            S_WB: begin
               if (w_rd != 5'd0)
                  r_x[w_rd] <= (w_opc == OPC_LOAD) ? r_mdr : r_aluout;
               r_pc <= r_pc + PC_INC;
            end
            default: ;
         endcase
      end
   end

`ifdef RETIRE_COUNT_EN
   logic [31:0] r_retire_cnt;
   logic        w_retire;

   assign w_retire = (r_state == S_WB)
                   || ((r_state == S_EXEC) && (w_opc == OPC_BRANCH))
                   || ((r_state == S_MEM) && bus.dm_ready && (w_opc == OPC_STORE));

   // retired-instruction counter, wraps naturally at 2^32
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)        r_retire_cnt <= '0;
      else if (w_retire) r_retire_cnt <= r_retire_cnt + 32'd1;
   end

   assign retire_cnt = r_retire_cnt;
`else
   assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed testbench for multicycle_datapath: small programs in a behavioural
// instruction/data memory, with hand-computed expected PCs and memory words.
module tb_multicycle_datapath;
   localparam int XLEN  = 64;
   localparam int IM_AW = 8;
   localparam int DM_AW = 5;
   localparam logic [63:0] PAT = 64'hA5A5_0000_0000_0000;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        halted;
   logic [31:0] retire_cnt;

   always #5 CLK = ~CLK;

   multicycle_datapath_if #(.XLEN(XLEN), .IM_AW(IM_AW), .DM_AW(DM_AW)) bus();

   multicycle_datapath #(.XLEN(XLEN), .IM_AW(IM_AW), .DM_AW(DM_AW)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .bus        (bus),
      .halted     (halted),
      .retire_cnt (retire_cnt)
   );

   logic [31:0] imem [0:255];
   logic [63:0] dmem [0:31];
   logic        hold     = 1'b0;
   logic        stall_en = 1'b0;
   logic        init_req = 1'b0;
   int          stall_cnt = 0;
   int          seen_cnt  = 0;
   int          seen_ok   = 0;
   int          n_chk     = 0;
   int          n_pass    = 0;
   logic [31:0] exp_ret;

   assign bus.im_data  = imem[bus.im_addr];
   assign bus.dm_rdata = dmem[bus.dm_addr];
   assign bus.dm_ready = !(hold || (stall_en && bus.dm_req && bus.dm_we &&
                                    (bus.dm_addr == 5'd1) && (stall_cnt < 3)));

   // data memory and stall counter
   always @(posedge CLK) begin
      if (init_req) begin
         for (int i = 0; i < 32; i++) dmem[i] <= PAT | 64'(i);
         stall_cnt <= 0;
      end else begin
         if (bus.dm_req && bus.dm_ready && bus.dm_we) dmem[bus.dm_addr] <= bus.dm_wdata;
         if (stall_en && bus.dm_req && bus.dm_we && (bus.dm_addr == 5'd1) && !bus.dm_ready)
            stall_cnt <= stall_cnt + 1;
      end
   end

   // watch the stalled store to word 1 for stable request/data
   always @(negedge CLK) begin
      if (bus.dm_req && bus.dm_we && (bus.dm_addr == 5'd1)) begin
         seen_cnt <= seen_cnt + 1;
         if (bus.dm_wdata == 64'd5) seen_ok <= seen_ok + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic hold_reset();
      RST_N = 1'b0;
      for (int i = 0; i < 256; i++) imem[i] = 32'h0;
      init_req = 1'b1;
      tick();
      init_req = 1'b0;
   endtask

   task automatic release_reset();
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic wait_halt(input int budget);
      int n;
      n = 0;
      while (!halted && n < budget) begin
         tick();
         n++;
      end
   endtask

   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                         input int rd, input logic [6:0] op);
      logic [11:0] im;
      im = imm[11:0];
      return {im, 5'(rs1), 3'(f3), 5'(rd), op};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                         input int f3, input int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
      logic [11:0] im;
      im = imm[11:0];
      return {im[11:5], 5'(rs2), 5'(rs1), 3'b011, im[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                         input int f3);
      logic [12:0] im;
      im = imm[12:0];
      return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
   endfunction

   initial begin
`ifdef RETIRE_COUNT_EN
      exp_ret = 32'd3;
`else
      exp_ret = 32'd0;
`endif
      RST_N = 1'b0;
      repeat (2) tick();
      chk("rst_im_addr", 64'(bus.im_addr), 64'd0);
      chk("rst_dm_req",  64'(bus.dm_req),  64'd0);
      chk("rst_dm_we",   64'(bus.dm_we),   64'd0);
      chk("rst_halted",  64'(halted),      64'd0);
      chk("rst_retire",  64'(retire_cnt),  64'd0);

      // ---- program A: ALU ops, stores, stalled store, load, branches ----
      hold_reset();
      imem[0]  = enc_i(5, 0, 0, 1, 7'h13);        // addi x1,x0,5
      imem[1]  = enc_i(-3, 0, 0, 2, 7'h13);       // addi x2,x0,-3
      imem[2]  = enc_r(0, 2, 1, 0, 3);            // add x3,x1,x2
      imem[3]  = enc_r(32, 1, 2, 0, 4);           // sub x4,x2,x1
      imem[4]  = enc_r(0, 2, 1, 7, 8);            // and x8,x1,x2
      imem[5]  = enc_r(0, 2, 1, 6, 9);            // or  x9,x1,x2
      imem[6]  = enc_r(0, 2, 1, 4, 10);           // xor x10,x1,x2
      imem[7]  = enc_r(0, 1, 2, 2, 11);           // slt x11,x2,x1
      imem[8]  = enc_r(0, 1, 2, 3, 12);           // sltu x12,x2,x1
      imem[9]  = enc_i(240, 2, 7, 13, 7'h13);     // andi x13,x2,0xF0
      imem[10] = enc_s(0, 3, 0);                  // sd x3,0(x0)
      imem[11] = enc_s(16, 4, 0);                 // sd x4,16(x0)
      imem[12] = enc_s(32, 8, 0);                 // sd x8,32(x0)
      imem[13] = enc_s(40, 9, 0);                 // sd x9,40(x0)
      imem[14] = enc_s(48, 10, 0);                // sd x10,48(x0)
      imem[15] = enc_s(56, 11, 0);                // sd x11,56(x0)
      imem[16] = enc_s(64, 12, 0);                // sd x12,64(x0)
      imem[17] = enc_s(80, 13, 0);                // sd x13,80(x0)
      imem[18] = enc_s(8, 1, 0);                  // sd x1,8(x0)  (stalled)
      imem[19] = enc_i(8, 0, 3, 5, 7'h03);        // ld x5,8(x0)
      imem[20] = enc_s(72, 5, 0);                 // sd x5,72(x0)
      imem[21] = enc_b(8, 1, 1, 0);               // beq x1,x1,+8  -> 92
      imem[23] = enc_b(8, 1, 1, 1);               // bne x1,x1,+8  not taken
      imem[24] = enc_b(8, 1, 2, 5);               // bge x2,x1,+8  not taken
      imem[25] = enc_b(8, 1, 2, 7);               // bgeu x2,x1,+8 -> 108
      stall_en = 1'b1;
      release_reset();
      repeat (12) tick();
      chk("a_pc_after_12", 64'(bus.im_addr), 64'd3);
      chk("a_retire_3",    64'(retire_cnt),  64'(exp_ret));
      wait_halt(1000);
      chk("a_halted",  64'(halted),      64'd1);
      chk("a_halt_pc", 64'(bus.im_addr), 64'd27);
      chk("a_add",  dmem[0],  64'd2);
      chk("a_sd_stall", dmem[1], 64'd5);
      chk("a_sub",  dmem[2],  64'hFFFF_FFFF_FFFF_FFF8);
      chk("a_untouched", dmem[3], PAT | 64'd3);
      chk("a_and",  dmem[4],  64'd5);
      chk("a_or",   dmem[5],  64'hFFFF_FFFF_FFFF_FFFD);
      chk("a_xor",  dmem[6],  64'hFFFF_FFFF_FFFF_FFF8);
      chk("a_slt",  dmem[7],  64'd1);
      chk("a_sltu", dmem[8],  64'd0);
      chk("a_ld",   dmem[9],  64'd5);
      chk("a_andi", dmem[10], 64'h0000_0000_0000_00F0);
      chk("a_stall_cycles", 64'(seen_cnt), 64'd4);
      chk("a_stall_wdata",  64'(seen_ok),  64'd4);
      chk("a_halt_req", 64'(bus.dm_req), 64'd0);

      // ---- program B: blt taken back to 8, then bltu not taken ----
      hold_reset();
      stall_en = 1'b0;
      imem[0] = enc_i(5, 0, 0, 1, 7'h13);         // addi x1,x0,5
      imem[1] = enc_i(-3, 0, 0, 2, 7'h13);        // addi x2,x0,-3
      imem[2] = enc_i(1, 0, 0, 6, 7'h13);         // addi x6,x0,1
      imem[3] = enc_i(2, 0, 0, 7, 7'h13);         // addi x7,x0,2
      imem[4] = enc_b(-8, 1, 2, 4);               // blt x2,x1,-8
      release_reset();
      repeat (18) tick();
      chk("b_blt_pending", 64'(bus.im_addr), 64'd4);
      tick();
      chk("b_blt_taken", 64'(bus.im_addr), 64'd2);
      hold_reset();
      imem[0] = enc_i(5, 0, 0, 1, 7'h13);
      imem[1] = enc_i(-3, 0, 0, 2, 7'h13);
      imem[2] = enc_i(1, 0, 0, 6, 7'h13);
      imem[3] = enc_i(2, 0, 0, 7, 7'h13);
      imem[4] = enc_b(-8, 1, 2, 6);               // bltu x2,x1,-8
      release_reset();
      repeat (19) tick();
      chk("b_bltu_not_taken", 64'(bus.im_addr), 64'd5);

      // ---- program D: write to x0 discarded, illegal opcode halts ----
      hold_reset();
      imem[0] = enc_i(7, 0, 0, 0, 7'h13);         // addi x0,x0,7
      imem[1] = enc_s(0, 0, 0);                   // sd x0,0(x0)
      release_reset();
      repeat (9) tick();
      chk("d_not_halted_yet", 64'(halted), 64'd0);
      tick();
      chk("d_halted",   64'(halted),      64'd1);
      chk("d_halt_pc",  64'(bus.im_addr), 64'd2);
      chk("d_x0_zero",  dmem[0],          64'd0);
      repeat (5) tick();
      chk("d_pc_frozen", 64'(bus.im_addr), 64'd2);
      chk("d_halt_req",  64'(bus.dm_req),  64'd0);
      chk("d_still_halted", 64'(halted),   64'd1);
      #2 RST_N = 1'b0;
      #1;
      chk("d_rst_halted", 64'(halted),      64'd0);
      chk("d_rst_pc",     64'(bus.im_addr), 64'd0);
      release_reset();
      tick();
      chk("d_refetch_pc", 64'(bus.im_addr), 64'd0);
      chk("d_refetch_run", 64'(halted),     64'd0);

      // ---- program E: reset while a store waits in MEM ----
      hold_reset();
      imem[0] = enc_i(9, 0, 0, 1, 7'h13);         // addi x1,x0,9
      imem[1] = enc_s(0, 1, 0);                   // sd x1,0(x0)
      hold = 1'b1;
      release_reset();
      repeat (7) tick();
      chk("e_mem_req",   64'(bus.dm_req),  64'd1);
      chk("e_mem_we",    64'(bus.dm_we),   64'd1);
      chk("e_mem_wdata", bus.dm_wdata,     64'd9);
      repeat (2) tick();
      chk("e_mem_held",  64'(bus.dm_req),  64'd1);
      #2 RST_N = 1'b0;
      #1;
      chk("e_rst_req", 64'(bus.dm_req), 64'd0);
      chk("e_rst_we",  64'(bus.dm_we),  64'd0);
      hold = 1'b0;
      tick();
      chk("e_no_write", dmem[0], PAT);
      release_reset();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
